// File: rtl/bus_pkg.sv
// Shared types and constants for the command-to-packet assembler.
package bus_pkg;

  typedef enum logic [2:0] {
    CMD_READ  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_ERASE = 3'd2,
    CMD_FLUSH = 3'd3
  } command_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2,
    ERROR  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        valid;
    logic        ready;
  } transaction_s;

  typedef struct packed {
    transaction_s request;
    transaction_s response;
    logic [3:0]   id;
  } bus_packet_s;

  localparam logic [31:0] ERASE_PATTERN    = 32'hFFFF_FFFF;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Data word sent to memory for a given operation; reads and flushes carry zero.
  function automatic logic [31:0] request_data(command_e op, logic [31:0] wdata);
    logic [31:0] d;
    d = '0;
    case (op)
      CMD_WRITE: d = wdata;
      CMD_ERASE: d = ERASE_PATTERN;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/txn_timeout_counter.sv
// Cycle counter for one outstanding operation; flags the last permitted cycle.
module txn_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Clear on a new operation, otherwise count every cycle the operation is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/bus_packet_assembler.sv
// Turns one command into one memory transaction and emits the result as a packet.
//
// state  | meaning
// IDLE   | ready for a command once the previous packet is consumed
// ACTIVE | request presented to memory, waiting for it to be accepted
// WAIT   | request accepted, waiting for response data
// ERROR  | timeout; one cycle to load the error packet
module bus_packet_assembler
  import bus_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  command_e     cmd,
  input  logic [7:0]   cmd_addr,
  input  logic [31:0]  cmd_wdata,
  output transaction_s mem_req,
  input  transaction_s mem_rsp,
  output logic         pkt_valid,
  input  logic         pkt_ready,
  output bus_packet_s  pkt,
  output state_e       state,
  output logic [7:0]   err_count
);

  state_e       state_r;
  state_e       state_next;
  command_e     cmd_q;
  logic [7:0]   addr_q;
  logic [31:0]  wdata_q;
  logic [3:0]   tag_q;
  logic [3:0]   id_q;
  bus_packet_s  pkt_r;
  logic         pkt_valid_r;
  logic         pending_q;
  logic [7:0]   err_count_r;

  logic         accept;
  logic         load;
  logic         expired;
  transaction_s req_txn;
  transaction_s load_rsp;
  bus_packet_s  load_pkt;

  // The pending term keeps commands out during the cycle between loading a
  // packet and pkt_valid rising, so an op never starts before its predecessor
  // has been consumed.
  assign cmd_ready = (state_r == IDLE) && !pkt_valid_r && !pending_q;
  assign accept    = cmd_valid && cmd_ready;

  txn_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  ((state_r == ACTIVE) || (state_r == WAIT)),
    .expired (expired)
  );

  // Request fields as they appear both on the bus and in the packet.
  always_comb begin
    req_txn       = '0;
    req_txn.addr  = addr_q;
    req_txn.data  = request_data(cmd_q, wdata_q);
    req_txn.valid = 1'b1;
    req_txn.ready = 1'b0;
  end

  // Memory request strobes decoded from registered state only.
  always_comb begin
    mem_req       = '0;
    mem_req.addr  = addr_q;
    mem_req.data  = request_data(cmd_q, wdata_q);
    mem_req.valid = (state_r == ACTIVE) && (cmd_q != CMD_FLUSH);
    mem_req.ready = (state_r == WAIT);
  end

  // Next-state and packet-load decisions; completion takes priority over timeout.
  always_comb begin
    state_next = state_r;
    load       = 1'b0;
    load_rsp   = '0;
    case (state_r)
      IDLE: begin
        if (accept) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (cmd_q == CMD_FLUSH) begin
          load       = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          state_next = ERROR;
        end else if (mem_rsp.ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp.valid) begin
          load           = 1'b1;
          load_rsp.addr  = mem_rsp.addr;
          load_rsp.data  = mem_rsp.data;
          load_rsp.valid = 1'b1;
          state_next     = IDLE;
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      ERROR: begin
        load          = 1'b1;
        load_rsp.addr = addr_q;
        load_rsp.data = ERR_DATA;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
    load_pkt = '{request: req_txn, response: load_rsp, id: tag_q};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next;
  end

  // Command capture, id tagging, packet register and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= CMD_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      id_q        <= '0;
      pkt_r       <= '0;
      pkt_valid_r <= 1'b0;
      pending_q   <= 1'b0;
      err_count_r <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        tag_q   <= id_q;
        id_q    <= id_q + 4'd1;
      end
      pending_q <= load;
      if (load) pkt_r <= load_pkt;
      if (pending_q)                     pkt_valid_r <= 1'b1;
      else if (pkt_valid_r && pkt_ready) pkt_valid_r <= 1'b0;
      if ((state_r == ERROR) && (err_count_r != 8'hFF))
        err_count_r <= err_count_r + 8'd1;
    end
  end

  assign pkt       = pkt_r;
  assign pkt_valid = pkt_valid_r;
  assign state     = state_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_bus_packet_assembler.sv
// Randomized directed bench for bus_packet_assembler with a transaction-level model.
module tb_bus_packet_assembler;
  import bus_pkg::*;

  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  command_e     cmd;
  logic [7:0]   cmd_addr;
  logic [31:0]  cmd_wdata;
  transaction_s mem_req;
  transaction_s mem_rsp;
  logic         pkt_valid;
  logic         pkt_ready;
  bus_packet_s  pkt;
  state_e       state;
  logic [7:0]   err_count;

  int total = 0;
  int bad   = 0;
  int id_next = 0;
  int errs    = 0;

  bus_packet_assembler #(.TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .mem_req   (mem_req),
    .mem_rsp   (mem_rsp),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt       (pkt),
    .state     (state),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_valid = 1'b0; pkt_ready = 1'b0; mem_rsp = '0;
    cmd = CMD_READ; cmd_addr = '0; cmd_wdata = '0;
    tick; tick;
    rst = 1'b0;
    id_next = 0;
    errs = 0;
  endtask

  function automatic logic [31:0] exp_req_data(command_e c, logic [31:0] w);
    if (c == CMD_WRITE) return w;
    if (c == CMD_ERASE) return 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  // One full operation: memory accepts after rdy cycles in ACTIVE, answers vld
  // cycles into WAIT; the consumer stalls for hold cycles before taking the packet.
  task automatic run_op(input command_e c, input logic [7:0] a, input logic [31:0] w,
                        input int rdy, input int vld, input int hold);
    int L, end_c, act_end, pv;
    bit ok, fl;
    state_e st;
    bus_packet_s exp_pkt;
    logic [7:0]  ra;
    logic [31:0] rd;
    ra = 8'($urandom);
    rd = $urandom;
    fl = (c == CMD_FLUSH);
    if (fl) begin
      ok = 1'b1; end_c = 0; act_end = 0; pv = 2;
    end else begin
      L       = rdy + vld + 2;
      ok      = (L <= TIMEOUT);
      end_c   = ok ? L - 1 : TIMEOUT - 1;
      act_end = (rdy < end_c) ? rdy : end_c;
      pv      = ok ? L + 1 : TIMEOUT + 2;
    end
    exp_pkt.request = '{addr: a, data: exp_req_data(c, w), valid: 1'b1, ready: 1'b0};
    if (fl)      exp_pkt.response = '0;
    else if (ok) exp_pkt.response = '{addr: ra, data: rd, valid: 1'b1, ready: 1'b0};
    else         exp_pkt.response = '{addr: a, data: 32'hDEAD_BEEF, valid: 1'b0, ready: 1'b0};
    exp_pkt.id = 4'(id_next);
    id_next = (id_next + 1) % 16;
    if (!fl && !ok && errs < 255) errs++;

    chk("cmd_ready_idle", 96'(cmd_ready), 96'(1));
    cmd_valid = 1'b1; cmd = c; cmd_addr = a; cmd_wdata = w; mem_rsp = '0;
    tick;
    for (int k = 0; k < pv; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd = command_e'($urandom_range(0, 3));
      cmd_addr = 8'($urandom);
      cmd_wdata = $urandom;
      mem_rsp.addr  = ra;
      mem_rsp.data  = rd;
      mem_rsp.ready = (k <= end_c) && (k >= rdy);
      mem_rsp.valid = (k <= end_c) &&
                      ((k >= rdy + 1 + vld) || (k <= rdy && $urandom_range(0, 1) == 1));
      if (k <= act_end)               st = ACTIVE;
      else if (k <= end_c)            st = WAIT;
      else if (!ok && k == end_c + 1) st = ERROR;
      else                            st = IDLE;
      chk("state", 96'(state), 96'(st));
      chk("req_valid", 96'(mem_req.valid), 96'(!fl && k <= act_end));
      chk("req_ready", 96'(mem_req.ready), 96'(k > act_end && k <= end_c));
      chk("pkt_valid_low", 96'(pkt_valid), 96'(0));
      chk("cmd_ready_busy", 96'(cmd_ready), 96'(0));
      if (k == 0) begin
        chk("req_addr", 96'(mem_req.addr), 96'(a));
        chk("req_data", 96'(mem_req.data), 96'(exp_req_data(c, w)));
      end
      tick;
    end
    cmd_valid = 1'b0; mem_rsp = '0;
    for (int h = 0; h <= hold; h++) begin
      pkt_ready = (h == hold);
      chk("pkt_valid", 96'(pkt_valid), 96'(1));
      chk("pkt", 96'(pkt), 96'(exp_pkt));
      chk("cmd_ready_held", 96'(cmd_ready), 96'(0));
      chk("state_idle", 96'(state), 96'(IDLE));
      tick;
    end
    pkt_ready = 1'b0;
    chk("pkt_consumed", 96'(pkt_valid), 96'(0));
    chk("cmd_ready_free", 96'(cmd_ready), 96'(1));
    chk("err_count", 96'(err_count), 96'(errs));
  endtask

  initial begin
    do_reset;
    chk("rst_state", 96'(state), 96'(IDLE));
    chk("rst_pkt_valid", 96'(pkt_valid), 96'(0));
    chk("rst_pkt", 96'(pkt), 96'(0));
    chk("rst_err_count", 96'(err_count), 96'(0));
    chk("rst_req_valid", 96'(mem_req.valid), 96'(0));

    // Basic read, write/erase pair, flush, and a plain timeout.
    run_op(CMD_READ, 8'h10, 32'h0, 0, 0, 0);
    do_reset;
    run_op(CMD_WRITE, 8'h22, 32'hCAFE_F00D, 0, 0, 1);
    run_op(CMD_ERASE, 8'h23, 32'h1357_9BDF, 0, 0, 0);
    run_op(CMD_FLUSH, 8'h31, 32'h2468_ACE0, 0, 0, 2);
    run_op(CMD_READ, 8'h40, 32'h0, 0, 100, 0);

    // Seventeen random commands from reset: first packet stalls, ids wrap.
    do_reset;
    for (int i = 0; i < 17; i++)
      run_op(command_e'($urandom_range(0, 3)), 8'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             (i == 0) ? 5 : $urandom_range(0, 2));

    // Timeout boundaries: completion on the last cycle wins, one later loses.
    run_op(CMD_READ,  8'h50, 32'h0,         0, 14, 0);
    run_op(CMD_WRITE, 8'h51, 32'hA5A5_5A5A, 0, 15, 0);
    run_op(CMD_ERASE, 8'h52, 32'h0,         14, 0, 0);
    run_op(CMD_READ,  8'h53, 32'h0,         15, 0, 0);

    // Reset in WAIT drops the operation; a late response is ignored.
    chk("cmd_ready_pre_rst", 96'(cmd_ready), 96'(1));
    cmd_valid = 1'b1; cmd = CMD_READ; cmd_addr = 8'h44; cmd_wdata = '0;
    tick;
    cmd_valid = 1'b0; mem_rsp.ready = 1'b1;
    tick;
    mem_rsp.ready = 1'b0;
    tick;
    chk("wait_before_rst", 96'(state), 96'(WAIT));
    rst = 1'b1; mem_rsp.valid = 1'b1; mem_rsp.data = 32'h0BAD_0BAD;
    tick;
    rst = 1'b0; id_next = 0; errs = 0;
    chk("rst_wait_state", 96'(state), 96'(IDLE));
    chk("rst_wait_pkt_valid", 96'(pkt_valid), 96'(0));
    chk("rst_wait_err_count", 96'(err_count), 96'(0));
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("late_rsp_pkt_valid", 96'(pkt_valid), 96'(0));
      chk("late_rsp_state", 96'(state), 96'(IDLE));
    end
    mem_rsp = '0;
    run_op(CMD_READ, 8'h60, 32'h0, 1, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
